ad5662_spi_rx: RTL and testbench

AD5662_SPI_RX -- requirements
Module: ad5662_spi_rx

---
 rtl/ad5662_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/ad5662_spi_rx.sv | 166 ++++++++++++++++
 tb/tb_ad5662_spi_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ad5662_pkg.sv
// Shared AD5662 frame layout and receiver state encoding, used by both the
// receiver and the DAC driver side.
package ad5662_pkg;

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS + 1);
    localparam int unsigned DATA_MSB   = 15;
    localparam int unsigned PD_MSB     = 17;
    localparam int unsigned PD_LSB     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by one history register that produces
// single-cycle rise/fall pulses of the synchronized level.
module sync_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {2{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[0], async_in};
            prev_q <= sync_q[1];
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~prev_q;
    assign fall  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/ad5662_spi_rx.sv
// AD5662 SPI frame receiver with a stream-style output port.
// Optional SHIFT-state inactivity timeout: define AD5662_SPI_RX_TIMEOUT_EN.
import ad5662_pkg::*;

module ad5662_spi_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_n,
    input  logic             sclk,
    input  logic             din,
    output logic [15:0]      o_tdata,
    output logic [1:0]       o_pd,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_count,
    output logic [7:0]       err_count
);

    logic sync_level, sync_rise, sync_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic din_level, din_rise, din_fall;

    sync_edge_det #(.RESET_VAL(1'b1)) u_sync_n (
        .clk(clk), .reset(reset), .async_in(sync_n),
        .level(sync_level), .rise(sync_rise), .fall(sync_fall)
    );

    sync_edge_det #(.RESET_VAL(1'b1)) u_sclk (
        .clk(clk), .reset(reset), .async_in(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_det #(.RESET_VAL(1'b0)) u_din (
        .clk(clk), .reset(reset), .async_in(din),
        .level(din_level), .rise(din_rise), .fall(din_fall)
    );

    state_t                 state, state_next;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [FRAME_BITS-1:0]  shreg;
    logic [FRAME_BITS-1:0]  word;
    logic                   frame_done, frame_abort, shift_en, timeout_hit;
    logic [1:0]             flush_cnt;
    logic                   armed;
    logic                   unused_bits;

    assign word     = {shreg[FRAME_BITS-2:0], din_level};
    assign shift_en = (state == SHIFT) && sclk_fall && !sync_rise;

    // A frame may only start after sync_n has been seen high once the
    // synchronizer has flushed its reset value, so a sync_n held low
    // across reset does not fake a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            if (flush_cnt != 2'd3)
                flush_cnt <= flush_cnt + 2'd1;
            if ((flush_cnt == 2'd3 && sync_level) || sync_rise)
                armed <= 1'b1;
        end
    end

`ifdef AD5662_SPI_RX_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != SHIFT || sclk_fall)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TO_W'(1);
    end

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && sync_fall)
                    state_next = SHIFT;
            end
            SHIFT: begin
                if (sync_rise) begin
                    frame_abort = 1'b1;
                    state_next  = IDLE;
                end else if (sclk_fall) begin
                    if (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
                        frame_done = 1'b1;
                        state_next = HOLD;
                    end
                end else if (timeout_hit) begin
                    frame_abort = 1'b1;
                    state_next  = IDLE;
                end
            end
            HOLD: begin
                if (sync_rise)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            o_tdata     <= '0;
            o_pd        <= '0;
            o_tvalid    <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (state == IDLE && state_next == SHIFT) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (shift_en) begin
                shreg   <= word;
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end

            // A completed frame replaces the held word only if that word is
            // gone or being accepted this very cycle; otherwise it is dropped.
            if (frame_done) begin
                frame_count <= frame_count + CNT_W'(1);
                if (!o_tvalid || o_tready) begin
                    o_tdata  <= word[DATA_MSB:0];
                    o_pd     <= word[PD_MSB:PD_LSB];
                    o_tvalid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (o_tvalid && o_tready) begin
                o_tvalid <= 1'b0;
            end

            if (frame_abort && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    assign unused_bits = ^{sclk_level, sclk_rise, din_rise, din_fall,
                           shreg[FRAME_BITS-1], word[FRAME_BITS-1:PD_MSB+1]};

endmodule

// File: tb/tb_ad5662_spi_rx.sv
// Directed self-checking bench for ad5662_spi_rx; the timeout scenario runs
// when AD5662_SPI_RX_TIMEOUT_EN is defined.
module tb_ad5662_spi_rx;
    import ad5662_pkg::*;

    logic        clk = 1'b0;
    logic        reset, sync_n, sclk, din, o_tready;
    logic [15:0] o_tdata;
    logic [1:0]  o_pd;
    logic        o_tvalid, overrun;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    logic [15:0] last_data = '0;
    logic [1:0]  last_pd = '0;

    always #5 clk = ~clk;

    ad5662_spi_rx #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .sync_n(sync_n), .sclk(sclk), .din(din),
        .o_tdata(o_tdata), .o_pd(o_pd), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .overrun(overrun), .frame_count(frame_count), .err_count(err_count)
    );

    // Records each accepted word; inputs change on negedge, so #1 later the
    // handshake seen here is the one the DUT takes on the next posedge.
    always @(negedge clk) begin
        #1;
        if (!reset && o_tvalid && o_tready) begin
            hs_cnt    = hs_cnt + 1;
            last_data = o_tdata;
            last_pd   = o_pd;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        sync_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic send_bits(input logic [29:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din = bits[i];
            wait_clk(3);
            sclk = 1'b0;
            wait_clk(3);
            sclk = 1'b1;
        end
    endtask

    task automatic end_frame();
        wait_clk(3);
        sync_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
    endtask

    task automatic test_reset();
        reset = 1'b1; sync_n = 1'b1; sclk = 1'b1; din = 1'b0; o_tready = 1'b1;
        wait_clk(3);
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", o_tvalid); end
        checks++; if (o_tdata !== 16'h0000) begin errors++; $display("FAIL reset_tdata: got %h expected 0000", o_tdata); end
        checks++; if (o_pd !== 2'd0) begin errors++; $display("FAIL reset_pd: got %0d expected 0", o_pd); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        reset = 1'b0;
        wait_clk(6);
    endtask

    task automatic test_basic();
        int hs0 = hs_cnt;
        start_frame(); send_bits(30'h008000, 24); end_frame();
        checks++; if (hs_cnt - hs0 !== 1) begin errors++; $display("FAIL basic_words: got %0d expected 1", hs_cnt - hs0); end
        checks++; if (last_data !== 16'h8000) begin errors++; $display("FAIL basic_data: got %h expected 8000", last_data); end
        checks++; if (last_pd !== 2'd0) begin errors++; $display("FAIL basic_pd: got %0d expected 0", last_pd); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_frame_count: got %0d expected 1", frame_count); end
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL basic_tvalid_clear: got %b expected 0", o_tvalid); end
    endtask

    task automatic test_pd_full();
        int hs0 = hs_cnt;
        start_frame(); send_bits(30'h03FFFF, 24); end_frame();
        checks++; if (hs_cnt - hs0 !== 1) begin errors++; $display("FAIL full_words: got %0d expected 1", hs_cnt - hs0); end
        checks++; if (last_data !== 16'hFFFF) begin errors++; $display("FAIL full_data: got %h expected ffff", last_data); end
        checks++; if (last_pd !== 2'd3) begin errors++; $display("FAIL full_pd: got %0d expected 3", last_pd); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL full_frame_count: got %0d expected 2", frame_count); end
    endtask

    task automatic test_short();
        int hs0 = hs_cnt;
        start_frame(); send_bits(30'hABC, 12); end_frame();
        checks++; if (hs_cnt - hs0 !== 0) begin errors++; $display("FAIL short_words: got %0d expected 0", hs_cnt - hs0); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL short_err_count: got %0d expected 1", err_count); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL short_state: got %0d expected 0", dut.state); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL short_frame_count: got %0d expected 2", frame_count); end
    endtask

    task automatic test_long();
        int hs0 = hs_cnt;
        start_frame(); send_bits({24'h015A5A, 6'b111111}, 30); end_frame();
        checks++; if (hs_cnt - hs0 !== 1) begin errors++; $display("FAIL long_words: got %0d expected 1", hs_cnt - hs0); end
        checks++; if (last_data !== 16'h5A5A) begin errors++; $display("FAIL long_data: got %h expected 5a5a", last_data); end
        checks++; if (last_pd !== 2'd1) begin errors++; $display("FAIL long_pd: got %0d expected 1", last_pd); end
        checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL long_frame_count: got %0d expected 3", frame_count); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL long_err_count: got %0d expected 1", err_count); end
    endtask

    task automatic test_overrun();
        int hs0 = hs_cnt;
        o_tready = 1'b0;
        start_frame(); send_bits(30'h001234, 24); end_frame();
        start_frame(); send_bits(30'h02ABCD, 24); end_frame();
        checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL ovr_tvalid: got %b expected 1", o_tvalid); end
        checks++; if (o_tdata !== 16'h1234) begin errors++; $display("FAIL ovr_tdata: got %h expected 1234", o_tdata); end
        checks++; if (o_pd !== 2'd0) begin errors++; $display("FAIL ovr_pd: got %0d expected 0", o_pd); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
        checks++; if (frame_count !== 16'd5) begin errors++; $display("FAIL ovr_frame_count: got %0d expected 5", frame_count); end
        o_tready = 1'b1;
        wait_clk(3);
        checks++; if (hs_cnt - hs0 !== 1) begin errors++; $display("FAIL ovr_words: got %0d expected 1", hs_cnt - hs0); end
        checks++; if (last_data !== 16'h1234) begin errors++; $display("FAIL ovr_accepted: got %h expected 1234", last_data); end
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL ovr_tvalid_clear: got %b expected 0", o_tvalid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid_frame();
        int hs0;
        start_frame(); send_bits(30'h3FF, 10);
        do_reset();
        checks++; if ({o_tvalid, o_tdata, o_pd, overrun} !== 20'd0) begin errors++; $display("FAIL mid_reset_outputs: got %h expected 00000", {o_tvalid, o_tdata, o_pd, overrun}); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL mid_reset_frame_count: got %0d expected 0", frame_count); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL mid_reset_err_count: got %0d expected 0", err_count); end
        hs0 = hs_cnt;
        // sync_n is still low: the rest of this frame must be ignored
        send_bits(30'h3FFF, 14); end_frame();
        checks++; if (hs_cnt - hs0 !== 0) begin errors++; $display("FAIL held_low_words: got %0d expected 0", hs_cnt - hs0); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL held_low_frame_count: got %0d expected 0", frame_count); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL held_low_err_count: got %0d expected 0", err_count); end
        start_frame(); send_bits(30'h000042, 24); end_frame();
        checks++; if (hs_cnt - hs0 !== 1) begin errors++; $display("FAIL recover_words: got %0d expected 1", hs_cnt - hs0); end
        checks++; if (last_data !== 16'h0042) begin errors++; $display("FAIL recover_data: got %h expected 0042", last_data); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL recover_frame_count: got %0d expected 1", frame_count); end
    endtask

`ifdef AD5662_SPI_RX_TIMEOUT_EN
    task automatic test_timeout();
        int hs0 = hs_cnt;
        int cyc = 0;
        start_frame(); send_bits(30'h2AA, 10);
        while (dut.state !== IDLE && cyc < 100) begin
            wait_clk(1);
            cyc++;
        end
        checks++; if (cyc > 68) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected at most 68", cyc); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL timeout_err_count: got %0d expected 1", err_count); end
        sync_n = 1'b1;
        wait_clk(8);
        checks++; if (hs_cnt - hs0 !== 0) begin errors++; $display("FAIL timeout_words: got %0d expected 0", hs_cnt - hs0); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL timeout_err_after_rise: got %0d expected 1", err_count); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL timeout_frame_count: got %0d expected 1", frame_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_pd_full();
        test_short();
        test_long();
        test_overrun();
        test_reset_mid_frame();
`ifdef AD5662_SPI_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
